i2c_slave_regfile: RTL and testbench

//  Register-file back end for I2C_SLAVE; sits directly downstream of it on the byte interface.

---
 rtl/i2c_slave_regfile.sv | 136 +++++++++++++
 tb/tb_i2c_slave_regfile.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// Register-file back end for an I2C slave byte interface: pointer/data protocol decode,
// auto-incrementing read/write pointer, and a host port onto the same register array.
module i2c_slave_regfile #(
  parameter int                   REG_COUNT = 16,
  parameter int                   PTR_W     = 4,
  parameter logic [7:0]           RESET_VAL = 8'h00,
  parameter logic [REG_COUNT-1:0] RO_MASK   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       datareceive,
  input  logic             received,
  input  logic             sended,
  output logic [7:0]       datasend,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PTR,
    ST_WDATA,
    ST_RDATA
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;
  logic             r_rx_q;
  logic             r_tx_q;
  logic             w_rx_ev;
  logic             w_tx_ev;
  logic             w_i2c_we;
  logic [7:0]       r_mem [REG_COUNT];
  logic [REG_COUNT-1:0] w_sel_host;
  logic [REG_COUNT-1:0] w_sel_i2c;

  assign w_rx_ev = r_rx_q & ~received;
  assign w_tx_ev = r_tx_q & ~sended;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_rx_q  <= 1'b1;
      r_tx_q  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_rx_q  <= received;
      r_tx_q  <= sended;
    end
  end

  // start outranks stop, which outranks any byte event in the same cycle
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_i2c_we     = 1'b0;
    if (start) begin
      w_state_next = ST_ADDR;
    end else if (stop) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_rx_ev) w_state_next = datareceive[0] ? ST_RDATA : ST_PTR;
        end
        ST_PTR: begin
          if (w_rx_ev) begin
            w_ptr_next   = datareceive[PTR_W-1:0];
            w_state_next = ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (w_rx_ev) begin
            w_i2c_we   = ~RO_MASK[r_ptr];
            w_ptr_next = r_ptr + 1'b1;
          end
        end
        ST_RDATA: begin
          if (w_tx_ev) w_ptr_next = r_ptr + 1'b1;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_sel
      assign w_sel_host[gi] = host_we  && (host_addr == PTR_W'(gi));
      assign w_sel_i2c[gi]  = w_i2c_we && (r_ptr     == PTR_W'(gi));
    end
  endgenerate

  // Host write is applied last so it wins a same-index collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) r_mem[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (w_sel_host[i])     r_mem[i] <= host_wdata;
        else if (w_sel_i2c[i]) r_mem[i] <= datareceive;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      datasend   <= '0;
      host_rdata <= '0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      datasend   <= r_mem[r_ptr];
      host_rdata <= r_mem[host_addr];
      wr_stb     <= w_i2c_we;
      if (w_i2c_we) begin
        wr_addr <= r_ptr;
        wr_data <= datareceive;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Randomized self-checking bench for i2c_slave_regfile against a transaction-level model
// of the register array, pointer and protocol phase.
module tb_i2c_slave_regfile;
  localparam logic [15:0] RO = 16'h8000;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [7:0] datareceive;
  logic       received;
  logic       sended;
  logic [7:0] datasend;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;

  i2c_slave_regfile #(
    .REG_COUNT(16), .PTR_W(4), .RESET_VAL(8'h00), .RO_MASK(RO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .datareceive(datareceive), .received(received), .sended(sended),
    .datasend(datasend), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stb_seen = 0;
  int exp_stb_total = 0;

  // Model: phase 0 idle, 1 awaiting address byte, 2 awaiting pointer, 3 writing, 4 reading
  logic [7:0] m_mem [16];
  int m_ptr;
  int m_phase;

  always @(negedge clk) if (reset && wr_stb) stb_seen++;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
    m_phase = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stb_seen = 0;
    exp_stb_total = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    m_phase = 1;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    m_phase = 0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic hwe, input logic [3:0] ha,
                         input logic [7:0] hd);
    logic       e_stb;
    logic [3:0] e_addr;
    logic [7:0] e_data;
    e_stb = 1'b0; e_addr = '0; e_data = '0;
    case (m_phase)
      1: m_phase = b[0] ? 4 : 2;
      2: begin m_ptr = int'(b[3:0]); m_phase = 3; end
      3: begin
        if (!RO[m_ptr]) begin
          m_mem[m_ptr] = b; e_stb = 1'b1; e_addr = 4'(m_ptr); e_data = b;
        end
        m_ptr = (m_ptr + 1) % 16;
      end
      default: ;
    endcase
    if (hwe) m_mem[ha] = hd;
    if (e_stb) exp_stb_total++;
    @(negedge clk);
    datareceive = b; received = 1'b0;
    host_we = hwe; host_addr = ha; host_wdata = hd;
    @(negedge clk);
    received = 1'b1; host_we = 1'b0;
    checks++;
    if (wr_stb !== e_stb) begin
      errors++;
      $display("FAIL rx_wr_stb byte=%h got=%b exp=%b", b, wr_stb, e_stb);
    end
    if (e_stb) begin
      checks++;
      if (wr_addr !== e_addr || wr_data !== e_data) begin
        errors++;
        $display("FAIL rx_wr_info got=%h/%h exp=%h/%h", wr_addr, wr_data, e_addr, e_data);
      end
    end
    $display("rx byte=%h stb=%b addr=%h data=%h", b, wr_stb, wr_addr, wr_data);
  endtask

  task automatic rx_plain(input logic [7:0] b);
    rx_byte(b, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic check_datasend(input string tag);
    checks++;
    if (datasend !== m_mem[m_ptr]) begin
      errors++;
      $display("FAIL %s datasend got=%h exp=%h ptr=%0d", tag, datasend, m_mem[m_ptr], m_ptr);
    end
  endtask

  task automatic tx_pulse();
    if (m_phase == 4) m_ptr = (m_ptr + 1) % 16;
    @(negedge clk); sended = 1'b0;
    @(negedge clk); sended = 1'b1;
    @(negedge clk);
    check_datasend("tx");
    $display("tx datasend=%h ptr=%0d", datasend, m_ptr);
  endtask

  task automatic host_read(input logic [3:0] a, input string tag);
    @(negedge clk); host_addr = a;
    @(negedge clk);
    checks++;
    if (host_rdata !== m_mem[a]) begin
      errors++;
      $display("FAIL %s host_rdata[%0d] got=%h exp=%h", tag, a, host_rdata, m_mem[a]);
    end
    $display("host read addr=%0d data=%h", a, host_rdata);
  endtask

  task automatic check_stb_count(input string tag);
    checks++;
    if (stb_seen !== exp_stb_total) begin
      errors++;
      $display("FAIL %s wr_stb_count got=%0d exp=%0d", tag, stb_seen, exp_stb_total);
    end
  endtask

  task automatic test_reset();
    do_reset();
    host_read(4'd5, "reset");
    check_datasend("reset");
    checks++;
    if (wr_stb !== 1'b0 || wr_addr !== 4'h0 || wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_wr got=%b/%h/%h exp=0/0/00", wr_stb, wr_addr, wr_data);
    end
    check_stb_count("reset");
  endtask

  task automatic test_write_burst();
    pulse_start();
    rx_plain(8'hA0);
    rx_plain(8'h03);
    rx_plain(8'h11);
    rx_plain(8'h22);
    host_read(4'd3, "burst");
    host_read(4'd4, "burst");
    check_stb_count("burst");
  endtask

  task automatic test_write_read();
    pulse_start();
    rx_plain(8'hA1);
    repeat (2) @(negedge clk);
    check_datasend("rd_first");
    tx_pulse();
    tx_pulse();
    rx_plain(8'h5A);
    check_datasend("rd_rx_ignored");
    pulse_stop();
  endtask

  task automatic test_wrap_ro();
    pulse_start();
    rx_plain(8'hA0);
    rx_plain(8'hFF);
    rx_plain(8'h55);
    rx_plain(8'h66);
    host_read(4'd15, "wrap_ro");
    host_read(4'd0, "wrap");
    check_stb_count("wrap");
    pulse_start();
    rx_plain(8'hA1);
    repeat (2) @(negedge clk);
    check_datasend("wrap_ptr");
    pulse_stop();
  endtask

  task automatic test_collision();
    pulse_start();
    rx_plain(8'hA0);
    rx_plain(8'h02);
    rx_byte(8'h11, 1'b1, 4'd2, 8'h99);
    rx_byte(8'h33, 1'b1, 4'd9, 8'h77);
    host_read(4'd2, "collide_same");
    host_read(4'd3, "collide_diff_i2c");
    host_read(4'd9, "collide_diff_host");
    pulse_stop();
  endtask

  task automatic test_start_priority();
    pulse_start();
    rx_plain(8'hA0);
    rx_plain(8'h08);
    @(negedge clk);
    start = 1'b1; datareceive = 8'hC3; received = 1'b0;
    @(negedge clk);
    start = 1'b0; received = 1'b1;
    m_phase = 1;
    checks++;
    if (wr_stb !== 1'b0) begin
      errors++;
      $display("FAIL start_prio wr_stb got=%b exp=0", wr_stb);
    end
    rx_plain(8'hA1);
    repeat (2) @(negedge clk);
    check_datasend("start_prio");
    host_read(4'd8, "start_prio");
    pulse_stop();
    rx_plain(8'h44);
    check_stb_count("start_prio");
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      pulse_start();
      if ($urandom_range(0, 1) == 0) begin
        rx_plain(8'($urandom_range(0, 127)) << 1);
        rx_plain(8'($urandom));
        for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
          if ($urandom_range(0, 3) == 0)
            rx_byte(8'($urandom), 1'b1, 4'($urandom), 8'($urandom));
          else
            rx_plain(8'($urandom));
          if ($urandom_range(0, 5) == 0) tx_pulse();
        end
      end else begin
        rx_plain((8'($urandom_range(0, 127)) << 1) | 8'h01);
        repeat (2) @(negedge clk);
        check_datasend("rand_rd_first");
        for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
          tx_pulse();
          if ($urandom_range(0, 5) == 0) rx_plain(8'($urandom));
        end
      end
      if ($urandom_range(0, 1) == 0) pulse_stop();
      host_read(4'($urandom), "rand");
    end
    check_stb_count("rand");
  endtask

  task automatic test_abort();
    pulse_start();
    rx_plain(8'hA0);
    rx_plain(8'h06);
    rx_plain(8'h77);
    do_reset();
    rx_plain(8'h44);
    sended = 1'b0; @(negedge clk); sended = 1'b1;
    for (int i = 0; i < 16; i++) host_read(4'(i), "abort");
    check_datasend("abort");
    check_stb_count("abort");
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    datareceive = 8'h00; received = 1'b1; sended = 1'b1;
    host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
    model_clear();
    test_reset();
    test_write_burst();
    test_write_read();
    test_wrap_ro();
    test_collision();
    test_start_priority();
    test_random();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
